// File: rtl/wb_master_single.sv
// wb_master_single: Wishbone B4 classic single-transfer master.
//
// Each command accepted on req_i becomes one cyc/stb cycle on the bus. The
// master then waits for ack_i or err_i and reports the outcome with a one-cycle
// done_o pulse. err_o is valid together with done_o. A read that completes
// successfully updates rdata_o; every other outcome leaves rdata_o unchanged.
//
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort any cycle that gets no
// ack_i/err_i within TIMEOUT cycles. An aborted cycle reports err_o=1. Without
// the macro, no counter is built and the master waits on the bus indefinitely.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   req_i, we_i, addr_i, wdata_i,      local command; sampled only when idle
//   sel_i
//   busy_o, done_o, err_o, rdata_o     local status and read data
//   cyc_o, stb_o, we_o, adr_o, dat_o,  Wishbone master outputs
//   sel_o
//   dat_i, ack_i, err_i                Wishbone slave responses
module wb_master_single #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] sel_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [DW-1:0]   rdata_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [AW-1:0]   adr_o,
    output logic [DW-1:0]   dat_o,
    output logic [DW/8-1:0] sel_o,
    input  logic [DW-1:0]   dat_i,
    input  logic            ack_i,
    input  logic            err_i
);

    localparam int unsigned SW = DW / 8;

    // The counter is 16 bits wide, so TIMEOUT has to fit in it.
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
        $error("wb_master_single: TIMEOUT must be in 2..65535");
    end

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;

`ifdef WB_MASTER_TIMEOUT_EN
    // The counter sits at TIMEOUT-1 on the TIMEOUT-th bus edge.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    we_d    = we_i;
                    adr_d   = addr_i;
                    dat_d   = wdata_i;
                    sel_d   = sel_i;
                    cyc_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StBus;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StBus: begin
                if (ack_i || err_i) begin
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = err_i;
                    state_d = StDone;
                    // err_i beats ack_i, so read data is only taken on a clean ack.
                    if (!we_q && ack_i && !err_i) begin
                        rdata_d = dat_i;
                    end
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;
    assign we_o    = we_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign sel_o   = sel_q;

endmodule

// File: tb/tb_wb_master_single.sv
// Testbench for wb_master_single: directed scenarios plus randomized commands
// against a transaction-level model of latency, status and read data.
module tb_wb_master_single;

    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned SW        = DW / 8;
    localparam int unsigned TbTimeout = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
    logic          busy_o, done_o, err_o, cyc_o, stb_o, we_o;
    logic [DW-1:0] rdata_o, dat_o;
    logic [AW-1:0] adr_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] dat_i;
    logic          ack_i;
    logic          err_i;

    int n_vec = 0;
    int n_err = 0;

    // Slave behaviour: respond slv_wait cycles into the bus cycle with slv_resp
    // ({err,ack}); outside a bus cycle toggle ack/err randomly as noise.
    int            slv_wait  = 0;
    logic [1:0]    slv_resp  = 2'b01;
    bit            slv_fix   = 1'b0;
    logic [DW-1:0] slv_dat   = '0;
    logic [DW-1:0] rsp_dat   = '0;
    int            bus_cnt   = 0;

    // Reference model state: last successfully read word.
    logic [DW-1:0] model_rdata = '0;

    wb_master_single #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TbTimeout)
    ) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .sel_i   (sel),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .rdata_o (rdata_o),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .sel_o   (sel_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i),
        .err_i   (err_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cyc_o) begin
            if (bus_cnt == slv_wait) begin
                ack_i   = slv_resp[0];
                err_i   = slv_resp[1];
                rsp_dat = slv_fix ? slv_dat : DW'($urandom);
                dat_i   = rsp_dat;
            end else begin
                ack_i = 1'b0;
                err_i = 1'b0;
                dat_i = DW'($urandom);
            end
            bus_cnt++;
        end else begin
            bus_cnt = 0;
            ack_i   = 1'($urandom_range(0, 1));
            err_i   = 1'($urandom_range(0, 1));
            dat_i   = DW'($urandom);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cyc"},   cyc_o,   0);
        check_eq({tag, "_stb"},   stb_o,   0);
        check_eq({tag, "_busy"},  busy_o,  0);
        check_eq({tag, "_done"},  done_o,  0);
        check_eq({tag, "_err"},   err_o,   0);
        check_eq({tag, "_rdata"}, rdata_o, 0);
        check_eq({tag, "_we"},    we_o,    0);
        check_eq({tag, "_adr"},   adr_o,   0);
        check_eq({tag, "_dat"},   dat_o,   0);
        check_eq({tag, "_sel"},   sel_o,   0);
    endtask

    task automatic scramble_cmd();
        we    = 1'($urandom_range(0, 1));
        addr  = AW'($urandom);
        wdata = DW'($urandom);
        sel   = SW'($urandom);
    endtask

    // One command; wt = wait cycles before the slave answers, rsp = {err,ack}.
    task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input int wt, input logic [1:0] rsp);
        int   n;
        int   exp_n;
        bit   timed_out;
        logic exp_err;
        slv_wait = wt;
        slv_resp = rsp;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(negedge clk);
        req = 1'b0;
        scramble_cmd();
        check_eq("start_cyc",  cyc_o,  1);
        check_eq("start_stb",  stb_o,  1);
        check_eq("start_busy", busy_o, 1);
        check_eq("start_we",   we_o,   w);
        check_eq("start_adr",  adr_o,  a);
        check_eq("start_dat",  dat_o,  d);
        check_eq("start_sel",  sel_o,  s);
        n = 0;
        while (!done_o && n < 200) begin
            if (cyc_o && (adr_o !== a || dat_o !== d || sel_o !== s || we_o !== w)) begin
                check_eq("bus_hold_adr", adr_o, a);
            end
            @(negedge clk);
            n++;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        timed_out = (rsp == 2'b00) || (wt >= int'(TbTimeout));
`else
        timed_out = 1'b0;
`endif
        exp_n   = timed_out ? int'(TbTimeout) : wt + 1;
        exp_err = timed_out ? 1'b1 : rsp[1];
        if (!timed_out && !w && rsp == 2'b01) begin
            model_rdata = rsp_dat;
        end
        check_eq("latency",    n,       exp_n);
        check_eq("done_pulse", done_o,  1);
        check_eq("end_cyc",    cyc_o,   0);
        check_eq("end_stb",    stb_o,   0);
        check_eq("end_busy",   busy_o,  0);
        check_eq("end_err",    err_o,   exp_err);
        check_eq("end_rdata",  rdata_o, model_rdata);
        check_eq("held_adr",   adr_o,   a);
        check_eq("held_we",    we_o,    w);
        @(negedge clk);
        check_eq("done_width", done_o,  0);
        check_eq("idle_rdata", rdata_o, model_rdata);
    endtask

    initial begin
        int  rises;
        int  dones;
        bit  prev;
        bit  stray_done;

        rst = 1'b1;
        req = 1'b0;
        scramble_cmd();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Read, single wait-free ack with a known word.
        slv_fix = 1'b1;
        slv_dat = 32'hDEADBEEF;
        run_cmd(1'b0, 32'h100, 32'h0, 4'hF, 0, 2'b01);
        slv_fix = 1'b0;

        // Write with 3 wait states.
        run_cmd(1'b1, 32'h10, 32'h55AA, 4'hF, 3, 2'b01);

        // Error beats ack: rdata stays at 1.
        slv_fix = 1'b1;
        slv_dat = 32'h1;
        run_cmd(1'b0, 32'h20, 32'h0, 4'hF, 1, 2'b01);
        slv_dat = 32'hCAFEF00D;
        run_cmd(1'b0, 32'h24, 32'h0, 4'hF, 0, 2'b11);
        check_eq("err_ack_rdata_hold", rdata_o, 32'h1);
        slv_fix = 1'b0;

        // req held for 6 edges: exactly 2 transactions.
        slv_wait = 1;
        slv_resp = 2'b01;
        rises = 0;
        dones = 0;
        prev  = cyc_o;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (cyc_o && !prev) rises++;
            if (done_o) dones++;
            prev  = cyc_o;
            req   = (i < 6);
            we    = 1'b1;
            addr  = 32'h40;
            wdata = 32'h1234;
            sel   = 4'h3;
        end
        check_eq("held_req_cycles", rises, 2);
        check_eq("held_req_dones",  dones, 2);

        // Reset in the middle of a bus cycle.
        slv_wait = 1000;
        slv_resp = 2'b01;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h80; wdata = 32'h0; sel = 4'hF;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;
        check_all_zero("midreset");
        stray_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done_o) stray_done = 1'b1;
        end
        check_eq("midreset_no_done", stray_done, 0);
        run_cmd(1'b0, 32'h84, 32'h0, 4'hF, 2, 2'b01);

        // Silent slave.
`ifdef WB_MASTER_TIMEOUT_EN
        run_cmd(1'b0, 32'h90, 32'h0, 4'hF, 0, 2'b00);
        run_cmd(1'b0, 32'h94, 32'h0, 4'hF, TbTimeout - 1, 2'b01);
        run_cmd(1'b0, 32'h98, 32'h0, 4'hF, TbTimeout, 2'b01);
`else
        slv_wait = 0;
        slv_resp = 2'b00;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h90; wdata = 32'h0; sel = 4'hF;
        @(negedge clk);
        req = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("hang_cyc",  cyc_o,  1);
        check_eq("hang_busy", busy_o, 1);
        check_eq("hang_done", done_o, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;
        check_eq("hang_reset_cyc", cyc_o, 0);
`endif

        // Randomized commands.
        for (int k = 0; k < 40; k++) begin
            int         r;
            logic [1:0] rsp;
            r   = $urandom_range(0, 9);
            rsp = (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
            run_cmd(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom),
                    $urandom_range(0, 5), rsp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
